// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the instruction register / datapath and the CPU control FSM.
interface cpu_control_fsm_if;
  logic [5:0] Opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       R1orR3;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       MemtoReg;
  logic [3:0] State;
  logic       Halted;
  logic       Illegal;

  // Datapath side: supplies the opcode, consumes the strobes.
  modport master (
    output Opcode,
    input  PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, R1orR3, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource, MemtoReg, State, Halted, Illegal
  );

  // Control unit side.
  modport slave (
    input  Opcode,
    output PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, R1orR3, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, MemtoReg, State, Halted, Illegal
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: sequences datapath strobes from the IR opcode.
// Per-state strobes are registered from the next state; only the DECODE-cycle
// signals that depend on the live opcode (Illegal, R1orR3) are combinational.
module cpu_control_fsm #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110
) (
  input  logic             Clk,
  input  logic             Reset,
  cpu_control_fsm_if.slave ctrl
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW   = 6'b010000;
  localparam logic [OP_W-1:0] OP_SW   = 6'b010001;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b011000;
  localparam logic [OP_W-1:0] OP_J    = 6'b011100;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       r1_or_r3;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  state_t          state_q, nxt_state;
  logic [OP_W-1:0] op_q, nxt_op;
  ctrl_t           ctrl_q, nxt_ctrl, out_c;
  logic            force_zero_c;

  // Opcode classification.
  function automatic logic is_r(input logic [OP_W-1:0] op);
    return op[5:3] == 3'b000;
  endfunction

  function automatic logic is_i(input logic [OP_W-1:0] op);
    return op[5:3] == 3'b001;
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return is_r(op) || is_i(op) || op == OP_LW || op == OP_SW ||
           op == OP_BNE || op == OP_J || op == OP_HALT;
  endfunction

  function automatic logic uses_rs_port2(input logic [OP_W-1:0] op);
    return op == OP_SW || op == OP_BNE;
  endfunction

  // DECODE dispatch target for a given opcode; illegal opcodes fall back to FETCH.
  function automatic state_t dispatch(input logic [OP_W-1:0] op);
    if (is_r(op))                       return S_EXEC_R;
    else if (is_i(op))                  return S_EXEC_I;
    else if (op == OP_LW || op == OP_SW) return S_MEM_ADDR;
    else if (op == OP_BNE)              return S_BRANCH;
    else if (op == OP_J)                return S_JUMP;
    else if (op == OP_HALT)             return S_HALT;
    else                                return S_FETCH;
  endfunction

  // Moore strobe table: outputs of state s given the latched opcode op.
  function automatic ctrl_t moore_ctrl(input state_t s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.pc_source = 2'b00;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = op[2:0];
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = op[2:0];
      end
      S_ALU_WB: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: c.mem_read = 1'b1;
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: c.mem_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    if (s != S_FETCH && s != S_DECODE && s <= S_HALT)
      c.r1_or_r3 = uses_rs_port2(op);
    return c;
  endfunction

  // Next-state and next latched-opcode logic.
  always_comb begin
    nxt_state = S_FETCH;
    nxt_op    = op_q;
    case (state_q)
      S_FETCH:     nxt_state = S_DECODE;
      S_DECODE: begin
        nxt_state = dispatch(ctrl.Opcode);
        nxt_op    = ctrl.Opcode;
      end
      S_EXEC_R:    nxt_state = S_ALU_WB;
      S_EXEC_I:    nxt_state = S_ALU_WB;
      S_ALU_WB:    nxt_state = S_FETCH;
      S_MEM_ADDR:  nxt_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt_state = S_MEM_WB;
      S_MEM_WB:    nxt_state = S_FETCH;
      S_MEM_WRITE: nxt_state = S_FETCH;
      S_BRANCH:    nxt_state = S_FETCH;
      S_JUMP:      nxt_state = S_FETCH;
      S_HALT:      nxt_state = S_HALT;
      default:     nxt_state = S_FETCH;
    endcase
    nxt_ctrl = moore_ctrl(nxt_state, nxt_op);
  end

  // State, latched opcode and registered strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ctrl_q  <= moore_ctrl(S_FETCH, '0);
    end else begin
      state_q <= nxt_state;
      op_q    <= nxt_op;
      ctrl_q  <= nxt_ctrl;
    end
  end

  // Reset and stray encodings silence every output immediately.
  always_comb begin
    force_zero_c = Reset || (state_q > S_HALT);
    out_c        = force_zero_c ? '0 : ctrl_q;
    if (!force_zero_c && state_q == S_DECODE)
      out_c.r1_or_r3 = uses_rs_port2(ctrl.Opcode);
  end

  assign ctrl.PCWrite     = out_c.pc_write;
  assign ctrl.PCWriteCond = out_c.pc_write_cond;
  assign ctrl.MemRead     = out_c.mem_read;
  assign ctrl.MemWrite    = out_c.mem_write;
  assign ctrl.IRWrite     = out_c.ir_write;
  assign ctrl.R1orR3      = out_c.r1_or_r3;
  assign ctrl.RegWrite    = out_c.reg_write;
  assign ctrl.ALUSrcA     = out_c.alu_src_a;
  assign ctrl.ALUSrcB     = out_c.alu_src_b;
  assign ctrl.ALUOp       = out_c.alu_op;
  assign ctrl.PCSource    = out_c.pc_source;
  assign ctrl.MemtoReg    = out_c.mem_to_reg;
  assign ctrl.Halted      = out_c.halted;
  assign ctrl.State       = force_zero_c ? 4'd0 : state_q;
  assign ctrl.Illegal     = !force_zero_c && (state_q == S_DECODE) && !is_legal(ctrl.Opcode);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: expected per-cycle output vectors are
// queued as stimulus is applied and compared on the falling edge.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       r13;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       m2r;
    logic [3:0] st;
    logic       hlt;
    logic       ill;
  } obs_t;

  logic clk;
  logic rst;
  cpu_control_fsm_if ctrl_if ();

  cpu_control_fsm dut (
    .Clk   (clk),
    .Reset (rst),
    .ctrl  (ctrl_if.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];
  logic [5:0] m_opq = 6'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison; report it if the observed value differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    return (op[5:4] == 2'b00) || op == 6'b010000 || op == 6'b010001 ||
           op == 6'b011000 || op == 6'b011100 || op == 6'b111111;
  endfunction

  // Reference outputs for one cycle, written directly from the state table.
  function automatic obs_t model(input int st, input logic [5:0] opq,
                                 input logic [5:0] live, input logic r);
    obs_t o;
    o = '0;
    if (r) return o;
    o.st = 4'(st);
    case (st)
      0:  begin o.mr = 1; o.irw = 1; o.asb = 2'b01; o.aop = 3'b010; o.pcw = 1; end
      1:  begin
            o.asb = 2'b11; o.aop = 3'b010;
            o.ill = !legal(live);
            o.r13 = (live == 6'b010001) || (live == 6'b011000);
          end
      2:  begin o.asa = 1; o.asb = 2'b00; o.aop = opq[2:0]; end
      3:  begin o.asa = 1; o.asb = 2'b10; o.aop = opq[2:0]; end
      4:  o.rw = 1;
      5:  begin o.asa = 1; o.asb = 2'b10; o.aop = 3'b010; end
      6:  o.mr = 1;
      7:  begin o.rw = 1; o.m2r = 1; end
      8:  o.mw = 1;
      9:  begin o.asa = 1; o.asb = 2'b00; o.aop = 3'b110; o.pcwc = 1; o.pcs = 2'b01; end
      10: begin o.pcw = 1; o.pcs = 2'b10; end
      11: o.hlt = 1;
      default: o = '0;
    endcase
    if (st >= 2) o.r13 = (opq == 6'b010001) || (opq == 6'b011000);
    return o;
  endfunction

  // Apply inputs for the cycle following the next rising edge and queue its expectation.
  task automatic cyc(input logic r, input logic [5:0] op, input int st);
    @(posedge clk);
    #1;
    rst = r;
    ctrl_if.Opcode = op;
    sb.push_back(model(st, m_opq, op, r));
    if (r) m_opq = 6'd0;
    else if (st == 1) m_opq = op;
  endtask

  // One instruction: FETCH, DECODE, then the listed post-decode states.
  task automatic instr(input logic [5:0] op, input int n, input int s0,
                       input int s1, input int s2);
    cyc(1'b0, op, 0);
    cyc(1'b0, op, 1);
    if (n > 0) cyc(1'b0, op, s0);
    if (n > 1) cyc(1'b0, op, s1);
    if (n > 2) cyc(1'b0, op, s2);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pcw  = ctrl_if.PCWrite;
    o.pcwc = ctrl_if.PCWriteCond;
    o.mr   = ctrl_if.MemRead;
    o.mw   = ctrl_if.MemWrite;
    o.irw  = ctrl_if.IRWrite;
    o.r13  = ctrl_if.R1orR3;
    o.rw   = ctrl_if.RegWrite;
    o.asa  = ctrl_if.ALUSrcA;
    o.asb  = ctrl_if.ALUSrcB;
    o.aop  = ctrl_if.ALUOp;
    o.pcs  = ctrl_if.PCSource;
    o.m2r  = ctrl_if.MemtoReg;
    o.st   = ctrl_if.State;
    o.hlt  = ctrl_if.Halted;
    o.ill  = ctrl_if.Illegal;
    return o;
  endfunction

  // Compare the DUT against the oldest queued expectation each falling edge.
  always @(negedge clk) begin
    obs_t e, o;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      o = sample();
      check($sformatf("cycle_state%0d", e.st), 32'(o), 32'(e));
      check("pcw_excl_pcwc", 32'(o.pcw & o.pcwc), 32'd0);
      check("rw_excl_mw", 32'(o.rw & o.mw), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    ctrl_if.Opcode = 6'd0;
    cyc(1'b1, 6'd0, 0);
    cyc(1'b1, 6'd0, 0);
    instr(6'b000110, 2, 2, 4, 0);          // R-type, ALUOp=110
    instr(6'b001011, 2, 3, 4, 0);          // I-type, ALUOp=011
    cyc(1'b0, 6'b010000, 0);               // LW with opcode changing mid-flight
    cyc(1'b0, 6'b010000, 1);
    cyc(1'b0, 6'b111111, 5);
    cyc(1'b0, 6'b111111, 6);
    cyc(1'b0, 6'b111111, 7);
    instr(6'b010001, 2, 5, 8, 0);          // SW
    instr(6'b011000, 1, 9, 0, 0);          // BNE
    instr(6'b011100, 1, 10, 0, 0);         // J
    instr(6'b101010, 0, 0, 0, 0);          // illegal: back to FETCH
    instr(6'b000010, 2, 2, 4, 0);          // R-type after illegal
    cyc(1'b0, 6'b010000, 0);               // LW aborted by reset in MEM_READ
    cyc(1'b0, 6'b010000, 1);
    cyc(1'b0, 6'b010000, 5);
    cyc(1'b1, 6'b010000, 6);
    cyc(1'b0, 6'b000000, 0);
    cyc(1'b0, 6'b000000, 1);
    cyc(1'b0, 6'b000000, 2);
    cyc(1'b0, 6'b000000, 4);
    instr(6'b111111, 0, 0, 0, 0);          // HALT held for 20 cycles
    for (int i = 0; i < 20; i++) cyc(1'b0, 6'b000000, 11);
    cyc(1'b1, 6'b000000, 0);
    cyc(1'b0, 6'b000000, 0);
    cyc(1'b0, 6'b011100, 1);
    cyc(1'b0, 6'b011100, 10);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
